// File: rtl/csa_resolve.sv
// Carry-save resolver: folds the redundant pair from the 4x5 reduction stage into a
// binary sum and its rounded average through a 2-stage valid/ready pipeline.
module csa_resolve #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   out_sum,
    output logic [W-1:0] out_avg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ovf,
    output logic [15:0]  out_cnt
);

    localparam logic [W:0]   OVF_LIMIT  = (W+1)'(32'd124);
    localparam logic [W+1:0] ROUND_BIAS = (W+2)'(32'd2);

    logic         s1_valid_r;
    logic [3:0]   s1_lo_r;
    logic         s1_c4_r;
    logic [W-5:0] s1_a_hi_r;
    logic [W-5:0] s1_b_hi_r;

    logic [4:0]   lo_s;
    logic [W-4:0] hi_s;
    logic [W:0]   sum_s;
    logic         s2_load_s;
    logic         in_fire_s;
    logic         out_fire_s;

    // Low-nibble add, high-part resolve and handshake qualifiers
    always_comb begin
        lo_s       = {1'b0, in_a[3:0]} + {1'b0, in_b[3:0]};
        hi_s       = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{(W-4){1'b0}}, s1_c4_r};
        sum_s      = {hi_s, s1_lo_r};
        s2_load_s  = !out_valid || out_ready;
        in_ready   = !s1_valid_r || s2_load_s;
        in_fire_s  = in_valid && in_ready;
        out_fire_s = out_valid && out_ready;
    end

    // Stage 1: capture the low-nibble result and the untouched high parts
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_lo_r    <= 4'd0;
            s1_c4_r    <= 1'b0;
            s1_a_hi_r  <= '0;
            s1_b_hi_r  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (in_fire_s) begin
                s1_lo_r   <= lo_s[3:0];
                s1_c4_r   <= lo_s[4];
                s1_a_hi_r <= in_a[W-1:4];
                s1_b_hi_r <= in_b[W-1:4];
            end
        end
    end

    // Stage 2: resolved sum, rounded average and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_ovf   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_sum <= sum_s;
                out_avg <= W'(({1'b0, sum_s} + ROUND_BIAS) >> 2);
                if (sum_s > OVF_LIMIT) begin
                    out_ovf <= 1'b1;
                end
            end
        end
    end

    // Consumed-result counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt <= 16'd0;
        end else if (out_fire_s) begin
            out_cnt <= out_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_csa_resolve.sv
// Directed bench for csa_resolve: a queue-based model checks every cycle,
// and hand-computed literals pin the key scenarios.
module tb_csa_resolve;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [W:0]   out_sum;
    logic [W-1:0] out_avg;
    logic         out_valid;
    logic         out_ovf;
    logic [15:0]  out_cnt;

    csa_resolve #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(in_ready), .out_sum(out_sum), .out_avg(out_avg), .out_valid(out_valid),
        .out_ready(out_ready), .out_ovf(out_ovf), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int sum;
        int acc;
    } item_t;

    item_t       mq[$];
    int          cyc = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_ovf = 1'b0;
    bit          chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: accepted pairs queue up (at most two in flight); the head is shown
    // from the second clock edge after its capture until it is consumed.
    always @(negedge clk) begin : model
        bit    vis;
        bit    rdy;
        item_t it;
        vis = (mq.size() > 0) && (cyc > mq[0].acc);
        if (vis && mq[0].sum > 124) m_ovf = 1'b1;
        rdy = (mq.size() - ((vis && out_ready) ? 1 : 0)) < 2;
        if (chk_en) begin
            cmp("out_valid", out_valid, vis);
            if (rst_n || mq.size() == 0) cmp("in_ready", in_ready, rdy);
            if (vis) begin
                cmp("out_sum", out_sum, mq[0].sum);
                cmp("out_avg", out_avg, (mq[0].sum + 2) / 4);
            end
            cmp("out_ovf", out_ovf, m_ovf);
            cmp("out_cnt", out_cnt, m_cnt);
        end
        if (!rst_n) begin
            mq.delete();
            m_cnt  = 16'd0;
            m_ovf  = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (vis && out_ready) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (in_valid && rdy) begin
                it.sum = int'(in_a) + int'(in_b);
                it.acc = cyc + 1;
                mq.push_back(it);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b);
        int budget;
        bit done;
        budget = 20;
        done = 1'b0;
        in_a = W'(a);
        in_b = W'(b);
        in_valid = 1'b1;
        while (!done && budget > 0) begin
            #1;
            done = in_ready;
            step();
            budget--;
        end
        in_valid = 1'b0;
        if (!done) cmp("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        cmp("rst_in_ready", in_ready, 1);
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_out_cnt", out_cnt, 0);

        // Basic path: result shows exactly two edges after capture
        send(60, 64);
        cmp("basic_early", out_valid, 0);
        step();
        cmp("basic_valid", out_valid, 1);
        cmp("basic_sum", out_sum, 124);
        cmp("basic_avg", out_avg, 31);
        cmp("basic_ovf", out_ovf, 0);
        step();
        cmp("basic_cnt", out_cnt, 1);

        // Rounding, back-to-back with no bubbles
        send(3, 3);
        send(2, 3);
        cmp("rnd0_sum", out_sum, 6);
        cmp("rnd0_avg", out_avg, 2);
        send(1, 0);
        cmp("rnd1_sum", out_sum, 5);
        cmp("rnd1_avg", out_avg, 1);
        step();
        cmp("rnd2_valid", out_valid, 1);
        cmp("rnd2_sum", out_sum, 1);
        cmp("rnd2_avg", out_avg, 0);
        step();

        // Overflow is sticky
        send(127, 127);
        send(0, 0);
        cmp("ovf_sum", out_sum, 254);
        cmp("ovf_avg", out_avg, 64);
        cmp("ovf_flag", out_ovf, 1);
        step();
        cmp("ovf_zero_sum", out_sum, 0);
        cmp("ovf_sticky", out_ovf, 1);
        step();

        // Backpressure
        do_reset();
        out_ready = 1'b1;
        send(10, 20);
        send(5, 6);
        out_ready = 1'b0;
        in_a = 7'd100;
        in_b = 7'd27;
        in_valid = 1'b1;
        #1;
        cmp("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("bp_hold_valid", out_valid, 1);
            cmp("bp_hold_sum", out_sum, 30);
            cmp("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        send(100, 27);
        send(0, 1);
        repeat (4) step();
        cmp("bp_cnt", out_cnt, 4);
        cmp("bp_drained", out_valid, 0);
        cmp("bp_ovf", out_ovf, 1);

        // Reset mid-stall discards everything in flight
        do_reset();
        out_ready = 1'b0;
        send(100, 27);
        send(1, 2);
        step();
        cmp("stall_pre_ovf", out_ovf, 1);
        out_ready = 1'b1;
        rst_n = 1'b0;
        in_a = 7'd9;
        in_b = 7'd9;
        in_valid = 1'b1;
        step();
        rst_n = 1'b1;
        in_a = 7'd7;
        in_b = 7'd9;
        #1;
        cmp("rs_out_valid", out_valid, 0);
        cmp("rs_out_cnt", out_cnt, 0);
        cmp("rs_out_ovf", out_ovf, 0);
        cmp("rs_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        cmp("rs_not_yet", out_valid, 0);
        step();
        cmp("rs_new_valid", out_valid, 1);
        cmp("rs_new_sum", out_sum, 16);
        cmp("rs_new_avg", out_avg, 4);
        step();
        cmp("rs_quiet", out_valid, 0);
        cmp("rs_cnt", out_cnt, 1);

        // Counter wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_a = W'(i);
            in_b = W'(i * 3);
            in_valid = 1'b1;
            step();
        end
        cmp("wrap_pre", out_cnt, 65535);
        step();
        cmp("wrap_zero", out_cnt, 0);
        in_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csa_resolve.md
CSA_RESOLVE -- requirements
Module: csa_resolve

Carry-save resolver for the redundant pair produced by the 4x5 reduction stage. It pipelines the pair through a 2-stage carry-propagate adder, outputs the 4-pixel sum and its rounded average, and uses valid/ready handshakes on both sides.

Interface
REQ-001 Parameter: W, default 7, width of each carry-save input vector.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_a  input  W  carry-save vector 1 (sum/carry bits).
REQ-005 in_b  input  W  carry-save vector 2.
REQ-006 in_valid  input  1  in_a/in_b valid this cycle.
REQ-007 in_ready  output  1  block accepts the pair this cycle.
REQ-008 out_sum  output  W+1  resolved sum in_a+in_b.
REQ-009 out_avg  output  W  rounded average, (sum+2)>>2.
REQ-010 out_valid  output  1  out_sum/out_avg/out_ovf valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_ovf  output  1  sticky flag: an accepted pair resolved to more than 124 (4*31).
REQ-013 out_cnt  output  16  count of results consumed downstream.

Function
REQ-014 A transfer occurs on an input when in_valid && in_ready, and on an output when out_valid && out_ready.
REQ-015 Stage 1 computes the low nibble: lo = in_a[3:0] + in_b[3:0]. It registers lo[3:0], the carry c4 = lo[4], and in_a[W-1:4] and in_b[W-1:4], and sets s1_valid.
REQ-016 Stage 2 computes hi = a_hi + b_hi + c4. It registers out_sum = {hi, lo[3:0]} and out_avg = (out_sum+2)>>2, with a 9-bit intermediate truncated to W bits, and sets out_valid.
REQ-017 Latency is exactly 2 cycles from input transfer to out_valid when out_ready stays high.
REQ-018 Throughput is one pair per cycle when out_ready stays high; there are no bubbles.
REQ-019 Stage 2 loads when !out_valid || out_ready.
REQ-020 in_ready = !s1_valid || stage-2 load condition. The value is combinational and does not depend on in_valid.
REQ-021 When out_valid && !out_ready, out_sum, out_avg and out_valid hold stable.
REQ-022 When out_valid && !out_ready and s1_valid is set, stage 1 also holds and in_ready = 0.
REQ-023 If stage 1 is empty during a stall, stage 1 may accept one pair. The pipeline then holds at most 2 results.
REQ-024 When an output transfer and a new stage-1 result occur in the same cycle, stage 2 reloads; out_valid stays 1.
REQ-025 When an output transfer occurs with stage 1 empty, out_valid drops to 0 on the next cycle.
REQ-026 out_ovf is set when stage 2 loads a sum > 124. It stays set until reset and is never cleared by traffic.
REQ-027 out_cnt increments by 1 on each output transfer and wraps from 65535 to 0.
REQ-028 Arithmetic is unsigned throughout; no input values are illegal.
REQ-029 The maximum sum is 2*(2^W-1) = 254, which fits in W+1 bits without loss.
REQ-030 There are no combinational paths from in_a/in_b to outputs. The only combinational path is out_ready -> in_ready.

Reset
REQ-031 While rst_n = 0 at a clock edge, the following are cleared: s1_valid, out_valid, out_sum, out_avg, out_ovf and out_cnt. All cleared values are 0.
REQ-032 During reset, in_ready = 1, following REQ-020 with an empty pipeline.
REQ-033 Reset asserted mid-operation discards in-flight pairs, including a stalled stage 2. No output transfer occurs on the reset cycle.
REQ-034 On the first cycle after rst_n rises, the block accepts input.
REQ-035 A pair presented during reset is not captured.

Verification
REQ-036 Basic path: in_a=60, in_b=64, in_valid=1 for one cycle, out_ready=1. Required: out_valid high exactly 2 cycles later; out_sum=124, out_avg=31, out_ovf=0, out_cnt goes to 1.
REQ-037 Rounding: pairs (3,3), (2,3), (1,0) back-to-back. Required: out_sum=6/5/1 and out_avg=2/1/0 on 3 consecutive cycles, with no bubbles.
REQ-038 Overflow: in_a=127, in_b=127. Required: out_sum=254, out_avg=64, out_ovf=1. out_ovf remains 1 after a following pair (0,0) resolves to out_sum=0.
REQ-039 Backpressure: stream 4 pairs with out_ready=0 from cycle 2. Required: in_ready falls after the 2nd accepted pair; outputs are held stable. On raising out_ready, results drain in order with none lost or duplicated; out_cnt=4.
REQ-040 Reset mid-stall: 2 pairs in flight, then rst_n=0 for 1 cycle. Required: out_valid=0, out_cnt=0, out_ovf=0 and in_ready=1 after reset, and nothing is emitted afterward.
REQ-041 Counter wrap: force 65536 output transfers. Required: out_cnt returns to 0.
